// File: rtl/jk_pkg.sv
// Shared definitions for the JK register bank: mode encoding and its width.
package jk_pkg;

    localparam int unsigned ModeWidth = 2;

    typedef enum logic [ModeWidth-1:0] {
        ModeHold  = 2'b00,
        ModeJk    = 2'b01,
        ModeCount = 2'b10,
        ModeLoad  = 2'b11
    } mode_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK bit-cell with asynchronous reset to a per-bit value and a parallel-load override.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    input  logic load,
    input  logic load_val,
    output logic q,
    output logic q_inverse
);

    logic j_eff;
    logic k_eff;
    logic q_d;
    logic q_q;

    // Load reuses the JK path: set when load_val=1, clear when load_val=0.
    always_comb begin
        j_eff = load ? load_val  : j;
        k_eff = load ? ~load_val : k;
        q_d   = (j_eff & ~q_q) | (~k_eff & q_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q         = q_q;
    assign q_inverse = ~q_q;

endmodule

// File: rtl/jk_register_bank.sv
// Bank of WIDTH JK cells with hold / per-bit JK / up-down count / parallel-load modes.
module jk_register_bank
    import jk_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ModeWidth-1:0] mode,
    input  logic [WIDTH-1:0]     j,
    input  logic [WIDTH-1:0]     k,
    input  logic                 up,
    input  logic [WIDTH-1:0]     load_data,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     q_inverse,
    output logic                 tc
);

    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic             load;
    logic             tc_d;
    logic             tc_q;

    assign load = en && (mode == ModeLoad);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Counter bit toggles once every lower bit is at its carry/borrow value.
        if (i == 0) begin : g_lsb
            assign toggle[i] = 1'b1;
        end else begin : g_upper
            assign toggle[i] = up ? (&q[i-1:0]) : ~(|q[i-1:0]);
        end

        always_comb begin
            cell_j[i] = 1'b0;
            cell_k[i] = 1'b0;
            if (en) begin
                case (mode)
                    ModeJk: begin
                        cell_j[i] = j[i];
                        cell_k[i] = k[i];
                    end
                    ModeCount: begin
                        cell_j[i] = toggle[i];
                        cell_k[i] = toggle[i];
                    end
                    default: begin
                        cell_j[i] = 1'b0;
                        cell_k[i] = 1'b0;
                    end
                endcase
            end
        end

        jk_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .rst_val   (RESET_VALUE[i]),
            .j         (cell_j[i]),
            .k         (cell_k[i]),
            .load      (load),
            .load_val  (load_data[i]),
            .q         (q[i]),
            .q_inverse (q_inverse[i])
        );
    end

    // Wrap happens on this edge when counting from all-ones up or from zero down.
    assign tc_d = en && (mode == ModeCount) && (up ? (&q) : ~(|q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= tc_d;
        end
    end

    assign tc = tc_q;

endmodule

// File: tb/tb_jk_register_bank.sv
// Self-checking bench: directed vector table, hand-written reset sequences, random vs. model.
module tb_jk_register_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic       up;
    logic [3:0] load_data;
    logic [3:0] q1, qi1, q2, qi2;
    logic       tc1, tc2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jk_register_bank #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .up(up),
        .load_data(load_data), .q(q1), .q_inverse(qi1), .tc(tc1)
    );

    jk_register_bank #(.WIDTH(4), .RESET_VALUE(4'b0101)) dut_rv5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .up(up),
        .load_data(load_data), .q(q2), .q_inverse(qi2), .tc(tc2)
    );

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [3:0] j;
        logic [3:0] k;
        logic       up;
        logic [3:0] ld;
        logic [3:0] eq;
        logic       etc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic e, logic [1:0] md, logic [3:0] jj, logic [3:0] kk,
                                logic u, logic [3:0] ld, logic [3:0] eq, logic etc);
        vec_t v;
        v.en = e; v.mode = md; v.j = jj; v.k = kk; v.up = u; v.ld = ld; v.eq = eq; v.etc = etc;
        return v;
    endfunction

    // Behavioural next state {tc, q} from the mode rules, using plain arithmetic.
    function automatic logic [4:0] model_next(logic [3:0] cur, logic e, logic [1:0] md,
                                              logic [3:0] jj, logic [3:0] kk, logic u,
                                              logic [3:0] ld);
        logic [3:0] n;
        logic       t;
        int         v;
        n = cur;
        t = 1'b0;
        if (e) begin
            case (md)
                2'd1: begin
                    for (int b = 0; b < 4; b++) begin
                        case ({jj[b], kk[b]})
                            2'b01:   n[b] = 1'b0;
                            2'b10:   n[b] = 1'b1;
                            2'b11:   n[b] = ~cur[b];
                            default: n[b] = cur[b];
                        endcase
                    end
                end
                2'd2: begin
                    v = (int'(cur) + (u ? 1 : 15)) % 16;
                    n = v[3:0];
                    t = u ? (cur == 4'd15) : (cur == 4'd0);
                end
                2'd3: n = ld;
                default: n = cur;
            endcase
        end
        return {t, n};
    endfunction

    task automatic check(string name, logic [3:0] aq, logic [3:0] aqi, logic atc,
                         logic [3:0] eq, logic etc);
        tests++;
        if (aq !== eq || aqi !== ~eq || atc !== etc) begin
            fails++;
            $display("FAIL %s: got q=%b q_inverse=%b tc=%b, want q=%b q_inverse=%b tc=%b",
                     name, aq, aqi, atc, eq, ~eq, etc);
        end
    endtask

    task automatic drive(logic e, logic [1:0] md, logic [3:0] jj, logic [3:0] kk, logic u,
                         logic [3:0] ld);
        en = e; mode = md; j = jj; k = kk; up = u; load_data = ld;
    endtask

    logic [3:0] m1, m2;
    logic [4:0] r1, r2;

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 4'h0);
        #1;
        check("reset_rv0", q1, qi1, tc1, 4'b0000, 1'b0);
        check("reset_rv5", q2, qi2, tc2, 4'b0101, 1'b0);

        // Edges under reset must not count.
        drive(1'b1, 2'd2, 4'h0, 4'h0, 1'b1, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check("edges_in_reset", q1, qi1, tc1, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back(mk(1, 2'd3, 4'h0, 4'h0, 0, 4'b1110, 4'b1110, 0));
        vecs.push_back(mk(1, 2'd2, 4'h0, 4'h0, 1, 4'h0,    4'b1111, 0));
        vecs.push_back(mk(1, 2'd2, 4'h0, 4'h0, 1, 4'h0,    4'b0000, 1));
        vecs.push_back(mk(1, 2'd2, 4'h0, 4'h0, 1, 4'h0,    4'b0001, 0));
        vecs.push_back(mk(1, 2'd3, 4'h0, 4'h0, 0, 4'b0001, 4'b0001, 0));
        vecs.push_back(mk(1, 2'd2, 4'h0, 4'h0, 0, 4'h0,    4'b0000, 0));
        vecs.push_back(mk(1, 2'd2, 4'h0, 4'h0, 0, 4'h0,    4'b1111, 1));
        vecs.push_back(mk(1, 2'd2, 4'h0, 4'h0, 0, 4'h0,    4'b1110, 0));
        vecs.push_back(mk(1, 2'd3, 4'h0, 4'h0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(1, 2'd1, 4'b1100, 4'b1010, 0, 4'h0, 4'b1100, 0));
        vecs.push_back(mk(1, 2'd1, 4'b1100, 4'b1010, 0, 4'h0, 4'b0100, 0));
        vecs.push_back(mk(1, 2'd3, 4'h0, 4'h0, 0, 4'b0011, 4'b0011, 0));
        vecs.push_back(mk(0, 2'd2, 4'h0, 4'h0, 1, 4'h0,    4'b0011, 0));
        vecs.push_back(mk(0, 2'd2, 4'h0, 4'h0, 1, 4'h0,    4'b0011, 0));
        vecs.push_back(mk(1, 2'd2, 4'h0, 4'h0, 1, 4'h0,    4'b0100, 0));
        vecs.push_back(mk(1, 2'd3, 4'h0, 4'h0, 0, 4'b1111, 4'b1111, 0));
        vecs.push_back(mk(1, 2'd2, 4'h0, 4'h0, 1, 4'h0,    4'b0000, 1));
        vecs.push_back(mk(0, 2'd2, 4'h0, 4'h0, 1, 4'h0,    4'b0000, 0));
        vecs.push_back(mk(1, 2'd2, 4'h0, 4'h0, 0, 4'h0,    4'b1111, 1));
        vecs.push_back(mk(1, 2'd2, 4'h0, 4'h0, 1, 4'h0,    4'b0000, 1));
        vecs.push_back(mk(1, 2'd0, 4'hF, 4'h0, 1, 4'hA,    4'b0000, 0));
        vecs.push_back(mk(1, 2'd1, 4'b0110, 4'b0110, 0, 4'h0, 4'b0110, 0));
        vecs.push_back(mk(1, 2'd2, 4'h0, 4'h0, 1, 4'h0,    4'b0111, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].mode, vecs[i].j, vecs[i].k, vecs[i].up, vecs[i].ld);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), q1, qi1, tc1, vecs[i].eq, vecs[i].etc);
        end

        // Asynchronous reset between edges.
        @(negedge clk);
        drive(1'b1, 2'd3, 4'h0, 4'h0, 1'b0, 4'b1010);
        @(posedge clk);
        #1;
        check("load_1010", q1, qi1, tc1, 4'b1010, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("async_rst", q1, qi1, tc1, 4'b0000, 1'b0);
        #1 rst = 1'b0;

        // Reset mid-count on the RESET_VALUE=0101 build.
        @(negedge clk);
        drive(1'b1, 2'd3, 4'h0, 4'h0, 1'b1, 4'b1001);
        @(posedge clk);
        #1;
        check("rv5_load_1001", q2, qi2, tc2, 4'b1001, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'd2, 4'h0, 4'h0, 1'b1, 4'h0);
        #1 rst = 1'b1;
        #1;
        check("rv5_mid_rst", q2, qi2, tc2, 4'b0101, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rv5_count_after_rst", q2, qi2, tc2, 4'b0110, 1'b0);
        check("rv0_count_after_rst", q1, qi1, tc1, 4'b0001, 1'b0);

        // Randomized stimulus against the model, with occasional mid-cycle resets.
        m1 = q1;
        m2 = q2;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 4'($urandom),
                  4'($urandom), 1'($urandom), 4'($urandom));
            if ($urandom_range(0, 29) == 0) begin
                #1 rst = 1'b1;
                #1;
                check("rand_rst_rv0", q1, qi1, tc1, 4'b0000, 1'b0);
                check("rand_rst_rv5", q2, qi2, tc2, 4'b0101, 1'b0);
                #1 rst = 1'b0;
                m1 = 4'b0000;
                m2 = 4'b0101;
            end
            r1 = model_next(m1, en, mode, j, k, up, load_data);
            r2 = model_next(m2, en, mode, j, k, up, load_data);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d_rv0", n), q1, qi1, tc1, r1[3:0], r1[4]);
            check($sformatf("rand%0d_rv5", n), q2, qi2, tc2, r2[3:0], r2[4]);
            m1 = r1[3:0];
            m2 = r2[3:0];
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
